// File: rtl/vec_store_unit.sv
// Vector store path: splits one VEC_W-bit vector into BEAT_W-bit write beats with
// lane-derived byte strobes, skipping fully-masked beats, and pulses done on retire.
module vec_store_unit #(
    parameter int VEC_W  = 512,
    parameter int BEAT_W = 128,
    parameter int LANE_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [VEC_W-1:0]          req_data,
    input  logic [VEC_W/LANE_W-1:0]   req_mask,
    output logic                      mem_wvalid,
    input  logic                      mem_wready,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [BEAT_W-1:0]         mem_wdata,
    output logic [BEAT_W/8-1:0]       mem_wstrb,
    output logic                      busy,
    output logic                      done
);

    localparam int NLANES = VEC_W / LANE_W;
    localparam int NBEATS = VEC_W / BEAT_W;
    localparam int LPB    = BEAT_W / LANE_W;
    localparam int BPB    = BEAT_W / 8;
    localparam int BPL    = LANE_W / 8;
    localparam int IDX_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [VEC_W-1:0]    data_q, data_d;
    logic [NLANES-1:0]   mask_q, mask_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                mem_wvalid_q, mem_wvalid_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [BEAT_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [BPB-1:0]      mem_wstrb_q, mem_wstrb_d;

    logic [VEC_W-1:0]    scan_data;
    logic [NLANES-1:0]   scan_mask;
    logic [ADDR_W-1:0]   scan_base;
    int                  scan_start;
    logic                found;
    int                  nxt_beat;
    logic [BEAT_W-1:0]   beat_wdata;
    logic [BPB-1:0]      beat_wstrb;
    logic [ADDR_W-1:0]   beat_addr;
    logic [ADDR_W-1:0]   aligned_addr;

    function automatic logic [BPB-1:0] lane_strb(input logic [LPB-1:0] lanes);
        logic [BPB-1:0] s;
        s = '0;
        for (int l = 0; l < LPB; l++) begin
            s[l*BPL +: BPL] = {BPL{lanes[l]}};
        end
        return s;
    endfunction

    assign aligned_addr = req_addr & ~ADDR_W'(BPB - 1);

    // One beat finder serves both the first beat on accept and every later advance.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        scan_data  = data_q;
        scan_mask  = mask_q;
        scan_base  = base_q;
        scan_start = int'(idx_q) + 1;
        if (state_q == S_IDLE) begin
            scan_data  = req_data;
            scan_mask  = req_mask;
            scan_base  = aligned_addr;
            scan_start = 0;
        end
        found    = 1'b0;
        nxt_beat = 0;
        for (int b = NBEATS - 1; b >= 0; b--) begin
            if (b >= scan_start && |scan_mask[b*LPB +: LPB]) begin
                found    = 1'b1;
                nxt_beat = b;
            end
        end
        beat_wdata = scan_data[nxt_beat*BEAT_W +: BEAT_W];
        beat_wstrb = lane_strb(scan_mask[nxt_beat*LPB +: LPB]);
        beat_addr  = scan_base + ADDR_W'(nxt_beat * BPB);
    end

    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        mask_d       = mask_q;
        base_d       = base_q;
        idx_d        = idx_q;
        mem_wvalid_d = mem_wvalid_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    data_d = req_data;
                    mask_d = req_mask;
                    base_d = aligned_addr;
                    if (found) begin
                        state_d      = S_SEND;
                        idx_d        = IDX_W'(nxt_beat);
                        mem_wvalid_d = 1'b1;
                        mem_addr_d   = beat_addr;
                        mem_wdata_d  = beat_wdata;
                        mem_wstrb_d  = beat_wstrb;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_SEND: begin
                // Beat outputs only move on a handshake, so they stay put under backpressure.
                if (mem_wready) begin
                    if (found) begin
                        idx_d       = IDX_W'(nxt_beat);
                        mem_addr_d  = beat_addr;
                        mem_wdata_d = beat_wdata;
                        mem_wstrb_d = beat_wstrb;
                    end else begin
                        state_d      = S_DONE;
                        mem_wvalid_d = 1'b0;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            data_q       <= '0;
            mask_q       <= '0;
            base_q       <= '0;
            idx_q        <= '0;
            mem_wvalid_q <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            mask_q       <= mask_d;
            base_q       <= base_d;
            idx_q        <= idx_d;
            mem_wvalid_q <= mem_wvalid_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign mem_wvalid = mem_wvalid_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wstrb  = mem_wstrb_q;

endmodule

// File: tb/tb_vec_store_unit.sv
// Directed bench for vec_store_unit: a table of store requests with hand-computed
// beats, plus backpressure and mid-store reset sequences.
module tb_vec_store_unit;

    logic          clk;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [31:0]   req_addr;
    logic [511:0]  req_data;
    logic [15:0]   req_mask;
    logic          mem_wvalid;
    logic          mem_wready;
    logic [31:0]   mem_addr;
    logic [127:0]  mem_wdata;
    logic [15:0]   mem_wstrb;
    logic          busy;
    logic          done;

    int checks   = 0;
    int failures = 0;

    vec_store_unit dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_mask   (req_mask),
        .mem_wvalid (mem_wvalid),
        .mem_wready (mem_wready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .busy       (busy),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    typedef struct {
        string              name;
        logic [31:0]        addr;
        logic [15:0]        mask;
        int                 nbeats;
        int                 edone;
        logic [3:0][1:0]    ebeat;
        logic [3:0][31:0]   eaddr;
        logic [3:0][15:0]   estrb;
    } vec_t;

    // Lane k of the stored vector holds k, so beat b carries lanes 4b..4b+3.
    logic [3:0][127:0] beat_data;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic [31:0] a, input logic [15:0] m,
                                input int nb, input int dn, input logic [3:0][1:0] bi,
                                input logic [3:0][31:0] ea, input logic [3:0][15:0] es);
        vec_t v;
        v.name = n; v.addr = a; v.mask = m; v.nbeats = nb; v.edone = dn;
        v.ebeat = bi; v.eaddr = ea; v.estrb = es;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lane_data();
        for (int k = 0; k < 16; k++) req_data[k*32 +: 32] = k;
    endtask

    // Issue one request and watch 20 cycles. Cycle 1 is the cycle after the accepting edge.
    task automatic run_store(input vec_t v, input int stall_at, input int stall_len);
        int nb, done_cyc, done_cnt, stalls;
        req_valid  = 1'b1;
        req_addr   = v.addr;
        req_mask   = v.mask;
        lane_data();
        mem_wready = 1'b1;
        check({v.name, "_ready_idle"}, req_ready, 1'b1);
        tick();
        // Post-accept request changes must not leak into the store.
        req_addr = 32'hDEAD_BEE0;
        req_mask = 16'hFFFF;
        req_data = {16{32'hBAD0_BAD0}};
        req_valid = (stall_len > 0);
        check({v.name, "_ready_busy"}, req_ready, 1'b0);
        nb = 0; done_cyc = -1; done_cnt = 0; stalls = 0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 3) req_valid = 1'b0;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
                check({v.name, "_busy_at_done"}, busy, 1'b1);
            end
            mem_wready = 1'b1;
            if (mem_wvalid) begin
                if (nb < 4) begin
                    check($sformatf("%s_addr%0d", v.name, nb), mem_addr, v.eaddr[nb]);
                    check($sformatf("%s_wdata%0d", v.name, nb), mem_wdata, beat_data[v.ebeat[nb]]);
                    check($sformatf("%s_wstrb%0d", v.name, nb), mem_wstrb, v.estrb[nb]);
                end
                if (nb == stall_at && stalls < stall_len) begin
                    mem_wready = 1'b0;
                    stalls++;
                end else begin
                    nb++;
                end
            end
            tick();
        end
        check({v.name, "_nbeats"}, nb, v.nbeats);
        check({v.name, "_done_cycle"}, done_cyc, v.edone);
        check({v.name, "_done_pulses"}, done_cnt, 1);
        check({v.name, "_idle_after"}, busy, 1'b0);
    endtask

    vec_t vecs[7];
    vec_t bp;

    initial begin
        beat_data[0] = 128'h00000003_00000002_00000001_00000000;
        beat_data[1] = 128'h00000007_00000006_00000005_00000004;
        beat_data[2] = 128'h0000000B_0000000A_00000009_00000008;
        beat_data[3] = 128'h0000000F_0000000E_0000000D_0000000C;

        vecs[0] = mk("full", 32'h1000, 16'hFFFF, 4, 5, {2'd3, 2'd2, 2'd1, 2'd0},
                     {32'h1030, 32'h1020, 32'h1010, 32'h1000},
                     {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF});
        vecs[1] = mk("sparse", 32'h1000, 16'h0F00, 1, 2, {2'd0, 2'd0, 2'd0, 2'd2},
                     {32'h0, 32'h0, 32'h0, 32'h1020}, {16'h0, 16'h0, 16'h0, 16'hFFFF});
        vecs[2] = mk("partial", 32'h1000, 16'h0005, 1, 2, {2'd0, 2'd0, 2'd0, 2'd0},
                     {32'h0, 32'h0, 32'h0, 32'h1000}, {16'h0, 16'h0, 16'h0, 16'h0F0F});
        vecs[3] = mk("zero", 32'h1000, 16'h0000, 0, 1, '0, '0, '0);
        vecs[4] = mk("wrap", 32'hFFFF_FFF7, 16'hFFFF, 4, 5, {2'd3, 2'd2, 2'd1, 2'd0},
                     {32'h20, 32'h10, 32'h0, 32'hFFFF_FFF0},
                     {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF});
        vecs[5] = mk("ends", 32'h2000, 16'hF00F, 2, 3, {2'd0, 2'd0, 2'd3, 2'd0},
                     {32'h0, 32'h0, 32'h2030, 32'h2000}, {16'h0, 16'h0, 16'hFFFF, 16'hFFFF});
        vecs[6] = mk("lanes", 32'h004C, 16'h8010, 2, 3, {2'd0, 2'd0, 2'd3, 2'd1},
                     {32'h0, 32'h0, 32'h70, 32'h50}, {16'h0, 16'h0, 16'hF000, 16'h000F});

        reset = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0; req_mask = '0;
        mem_wready = 1'b0;
        tick();
        tick();
        check("rst_wvalid", mem_wvalid, 1'b0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_wdata", mem_wdata, 128'h0);
        check("rst_wstrb", mem_wstrb, 16'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        reset = 1'b1;
        // wready with no beat outstanding must be harmless.
        mem_wready = 1'b1;
        tick();
        check("rst_ready", req_ready, 1'b1);
        check("idle_wready_wvalid", mem_wvalid, 1'b0);

        for (int i = 0; i < 7; i++) run_store(vecs[i], -1, 0);

        // Backpressure: beat 1 held for 3 extra cycles, request line wiggled while busy.
        bp = vecs[0];
        bp.name  = "backpressure";
        bp.edone = 8;
        run_store(bp, 1, 3);

        // Reset while beat 2 is on the bus.
        req_valid = 1'b1; req_addr = 32'h1000; req_mask = 16'hFFFF; lane_data();
        mem_wready = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        check("midrst_beat2_valid", mem_wvalid, 1'b1);
        check("midrst_beat2_addr", mem_addr, 32'h1020);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("midrst_wvalid", mem_wvalid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_addr", mem_addr, 32'h0);
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 6; c++) begin
                if (done || mem_wvalid) seen++;
                tick();
            end
            check("midrst_quiet", seen, 0);
        end
        run_store(vecs[1], -1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
